// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle between the arbiter, its NUM_MASTERS pipelined Wishbone masters and the shared slave.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface wb_rr_arbiter_if #(
  parameter int N  = 4,
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [N-1:0]        m_cyc;
  logic [N-1:0]        m_stb;
  logic [N-1:0]        m_we;
  logic [N*AW-1:0]     m_addr;
  logic [N*DW-1:0]     m_data;
  logic [N*DW/8-1:0]   m_sel;
  logic [N-1:0]        m_ack;
  logic [N-1:0]        m_stall;
  logic [N-1:0]        m_err;

  logic                s_cyc;
  logic                s_stb;
  logic                s_we;
  logic [AW-1:0]       s_addr;
  logic [DW-1:0]       s_data;
  logic [DW/8-1:0]     s_sel;
  logic                s_ack;
  logic                s_stall;
  logic                s_err;

  modport slave (
    input  m_cyc, m_stb, m_we, m_addr, m_data, m_sel,
    output m_ack, m_stall, m_err,
    output s_cyc, s_stb, s_we, s_addr, s_data, s_sel,
    input  s_ack, s_stall, s_err
  );

  modport master (
    output m_cyc, m_stb, m_we, m_addr, m_data, m_sel,
    input  m_ack, m_stall, m_err,
    input  s_cyc, s_stb, s_we, s_addr, s_data, s_sel,
    output s_ack, s_stall, s_err
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin pipelined Wishbone arbiter: one owner per cyc window, outstanding-request tracking,
// responses steered only to the owner.
//  state | meaning
//  IDLE  | no owner, slave cyc low, arbitrating among m_cyc requests
//  OWNED | owner_q routed to the slave until it drops m_cyc
module wb_rr_arbiter #(
  parameter int NUM_MASTERS      = 4,
  parameter int AW               = 32,
  parameter int DW               = 32,
  parameter int MAX_OUTSTANDING  = 8,
  parameter bit OPT_ZERO_ON_IDLE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  wb_rr_arbiter_if.slave         bus,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   proto_err
);
  localparam int N  = NUM_MASTERS;
  localparam int SW = DW / 8;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   grant_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [CW-1:0]  outst_q, outst_d;
  logic           stale_q, stale_d;
  logic           proto_d;

  logic [IW-1:0]  pick;
  logic           pick_vld;
  logic [IW-1:0]  idx;

  logic           stb;
  logic           resp;
  logic           busy;
  logic           sat;
  logic           acc;
  logic           dec;

  logic           pay_we;
  logic [AW-1:0]  pay_addr;
  logic [DW-1:0]  pay_data;
  logic [SW-1:0]  pay_sel;

  // Descending scan so the nearest requester after the last owner is the one that sticks.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = N; i >= 1; i--) begin
      idx = IW'((int'(owner_q) + i) % N);
      if (bus.m_cyc[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant;
    owner_d     = owner_q;
    outst_d     = outst_q;
    stale_d     = stale_q;
    proto_d     = proto_err;
    stb         = 1'b0;
    acc         = 1'b0;
    dec         = 1'b0;
    bus.s_cyc   = 1'b0;
    bus.m_stall = '1;
    bus.m_ack   = '0;
    bus.m_err   = '0;
    resp        = bus.s_ack | bus.s_err;
    busy        = (outst_q != '0);
    sat         = (outst_q == CW'(MAX_OUTSTANDING));

    case (state_q)
      IDLE: begin
        // Responses after a release that left requests in flight are expected stragglers.
        if (resp && !stale_q)
          proto_d = 1'b1;
        if (pick_vld) begin
          state_d = OWNED;
          grant_d = N'(1) << pick;
          owner_d = pick;
          stale_d = 1'b0;
        end
      end
      OWNED: begin
        if (bus.m_cyc[owner_q]) begin
          bus.s_cyc             = 1'b1;
          stb                   = bus.m_stb[owner_q] & ~sat;
          bus.m_stall[owner_q]  = bus.s_stall | sat;
          bus.m_ack[owner_q]    = bus.s_ack & busy;
          bus.m_err[owner_q]    = bus.s_err & busy;
          if (resp && !busy)
            proto_d = 1'b1;
          acc = stb & ~bus.s_stall;
          dec = resp & busy;
          if (acc && !dec)
            outst_d = outst_q + CW'(1);
          else if (dec && !acc)
            outst_d = outst_q - CW'(1);
        end else begin
          if (resp && !busy)
            proto_d = 1'b1;
          state_d = IDLE;
          grant_d = '0;
          outst_d = '0;
          stale_d = busy;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pay_we   = 1'b0;
    pay_addr = '0;
    pay_data = '0;
    pay_sel  = '0;
    for (int i = 0; i < N; i++) begin
      if (owner_q == IW'(i)) begin
        pay_we   = bus.m_we[i];
        pay_addr = bus.m_addr[i*AW +: AW];
        pay_data = bus.m_data[i*DW +: DW];
        pay_sel  = bus.m_sel[i*SW +: SW];
      end
    end
    if (OPT_ZERO_ON_IDLE && !stb) begin
      pay_we   = 1'b0;
      pay_addr = '0;
      pay_data = '0;
      pay_sel  = '0;
    end
  end

  assign bus.s_stb  = stb;
  assign bus.s_we   = pay_we;
  assign bus.s_addr = pay_addr;
  assign bus.s_data = pay_data;
  assign bus.s_sel  = pay_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant     <= '0;
      owner_q   <= IW'(N - 1);
      outst_q   <= '0;
      stale_q   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant     <= grant_d;
      owner_q   <= owner_d;
      outst_q   <= outst_d;
      stale_q   <= stale_d;
      proto_err <= proto_d;
    end
  end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: grant and response events are scoreboarded against queued
// expectations; stall/strobe/proto_err behaviour is checked inline.
module tb_wb_rr_arbiter;
  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_rr_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus ();
  logic [N-1:0] grant;
  logic         proto_err;

  wb_rr_arbiter #(
    .NUM_MASTERS(N), .AW(AW), .DW(DW),
    .MAX_OUTSTANDING(MAXO), .OPT_ZERO_ON_IDLE(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .grant(grant), .proto_err(proto_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [N-1:0]   exp_grant_q[$];
  logic [2*N-1:0] exp_resp_q[$];
  logic [N-1:0]   prev_grant = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every new owner and every routed response must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (grant !== prev_grant && grant != '0) begin
        if (exp_grant_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL grant_unexpected: got %b expected none", grant);
        end else
          check("grant_order", grant, exp_grant_q.pop_front());
      end
      prev_grant = grant;
      if ((|bus.m_ack) || (|bus.m_err)) begin
        if (exp_resp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL resp_unexpected: got err=%b ack=%b expected none", bus.m_err, bus.m_ack);
        end else
          check("resp_route", {bus.m_err, bus.m_ack}, exp_resp_q.pop_front());
      end
    end else
      prev_grant = '0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.m_cyc   = '0;
    bus.m_stb   = '0;
    bus.m_we    = '0;
    bus.s_ack   = 1'b0;
    bus.s_err   = 1'b0;
    bus.s_stall = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Owner k accepts n strobes in a row, then the next one is held off by saturation.
  task automatic expect_accepts(input string tag, input int k, input int n);
    for (int i = 0; i < n; i++) begin
      settle();
      check({tag, "_accept"}, {bus.m_stall[k], bus.s_stb}, 2'b01);
      step();
    end
    settle();
    check({tag, "_sat"}, {bus.m_stall[k], bus.s_stb}, 2'b10);
  endtask

  function automatic logic [AW-1:0] addr_of(input int k);
    return 32'hA000_0000 + 32'(k * 16);
  endfunction

  int k;

  initial begin
    clear_inputs();
    for (int i = 0; i < N; i++) begin
      bus.m_addr[i*AW +: AW]     = addr_of(i);
      bus.m_data[i*DW +: DW]     = 32'h5000_0000 + 32'(i);
      bus.m_sel[i*DW/8 +: DW/8]  = 4'hF;
    end

    // Reset state
    #2;
    check("rst_grant", grant, 0);
    check("rst_scyc", {bus.s_cyc, bus.s_stb}, 0);
    check("rst_stall", bus.m_stall, 4'hF);
    check("rst_resp", {bus.m_err, bus.m_ack}, 0);
    check("rst_proto", proto_err, 0);
    check("rst_zero_addr", bus.s_addr, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // T1: first pick after reset is master 0, then master 2 after the mandatory idle cycle
    bus.m_cyc = 4'b0101;
    exp_grant_q.push_back(4'b0001);
    settle();
    check("t1_idle_scyc", bus.s_cyc, 0);
    step();
    check("t1_owned_scyc", bus.s_cyc, 1);
    bus.m_cyc = 4'b0100;
    exp_grant_q.push_back(4'b0100);
    settle();
    check("t1_release_scyc", bus.s_cyc, 0);
    step();
    check("t1_idle_gap", grant, 0);
    step();
    check("t1_second_grant", grant, 4'b0100);
    bus.m_cyc = '0;
    step();
    do_reset();

    // T2: everyone requesting, one transfer each, rotation 0,1,2,3,0
    bus.m_cyc = '1;
    for (int r = 0; r < 5; r++) begin
      k = r % N;
      exp_grant_q.push_back(N'(1) << k);
      step();
      bus.m_stb = N'(1) << k;
      settle();
      check("t2_saddr", bus.s_addr, addr_of(k));
      step();
      bus.m_stb = '0;
      bus.s_ack = 1'b1;
      exp_resp_q.push_back({N'(0), N'(1) << k});
      step();
      bus.s_ack = 1'b0;
      bus.m_cyc[k] = 1'b0;
      step();
      bus.m_cyc[k] = 1'b1;
    end
    bus.m_cyc = '0;
    step();
    do_reset();

    // T3: saturation at MAXO outstanding, an err frees one slot
    bus.m_cyc = 4'b0010;
    exp_grant_q.push_back(4'b0010);
    step();
    bus.m_stb = 4'b0010;
    bus.m_we  = 4'b0010;
    expect_accepts("t3", 1, MAXO);
    check("t3_zero_addr", bus.s_addr, 0);
    check("t3_others_stall", bus.m_stall, 4'hF);
    bus.s_err = 1'b1;
    exp_resp_q.push_back({4'b0010, 4'b0000});
    step();
    bus.s_err = 1'b0;
    settle();
    check("t3_resume", {bus.m_stall[1], bus.s_stb, bus.s_we}, 3'b011);
    step();
    settle();
    check("t3_resat", {bus.m_stall[1], bus.s_stb}, 2'b10);
    bus.m_stb = '0;
    bus.m_cyc = '0;
    step();
    do_reset();

    // T4: ack together with an accepted strobe at 3 outstanding keeps the count at 3
    bus.m_cyc = 4'b0100;
    exp_grant_q.push_back(4'b0100);
    step();
    bus.m_stb = 4'b0100;
    repeat (3) step();
    bus.s_ack = 1'b1;
    exp_resp_q.push_back({4'b0000, 4'b0100});
    settle();
    check("t4_ack_owner_only", bus.m_ack, 4'b0100);
    step();
    bus.s_ack = 1'b0;
    expect_accepts("t4", 2, MAXO - 3);
    bus.m_stb = '0;
    bus.m_cyc = '0;
    step();
    do_reset();

    // T5: ack with nothing outstanding is dropped and latches proto_err until reset
    bus.m_cyc = 4'b0001;
    exp_grant_q.push_back(4'b0001);
    step();
    bus.s_ack = 1'b1;
    settle();
    check("t5_no_route", {bus.m_err, bus.m_ack}, 0);
    check("t5_pe_before", proto_err, 0);
    step();
    bus.s_ack = 1'b0;
    settle();
    check("t5_pe_set", proto_err, 1);
    bus.m_cyc = '0;
    repeat (3) step();
    check("t5_pe_sticky", proto_err, 1);
    do_reset();
    settle();
    check("t5_pe_cleared", proto_err, 0);

    // T6: reset mid-burst with 5 outstanding; master 0 wins afterwards with an empty counter
    bus.m_cyc = 4'b0100;
    exp_grant_q.push_back(4'b0100);
    step();
    bus.m_stb = 4'b0100;
    repeat (5) step();
    bus.m_stb = '0;
    bus.m_cyc = 4'b0101;
    rst_n = 1'b0;
    settle();
    check("t6_rst_scyc", bus.s_cyc, 0);
    check("t6_rst_grant", grant, 0);
    check("t6_rst_stall", bus.m_stall, 4'hF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_grant_q.push_back(4'b0001);
    step();
    check("t6_first_owner", grant, 4'b0001);
    bus.m_stb = 4'b0001;
    expect_accepts("t6", 0, MAXO);
    bus.m_stb = '0;
    bus.m_cyc = '0;
    repeat (2) step();

    check("queues_drained", exp_grant_q.size() + exp_resp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
